score4_move_ctrl: RTL
=====================

// Module: score4_move_ctrl
// PURPOSE
// - Move sequencer for the Score 4 board. Turns left/right/put button presses into cursor moves and single-cell board writes.
// - Owns the per-column fill heights, the player turn and the game-over lock.
// - Drives the panel state register's write port; receives win/full back from the winner and full-board checkers.
// PARAMETERS
// - COLS      7           board columns; cursor width
// - ROWS      6           board rows; row 0 is the bottom
// - TICK_DIV  2_500_000   clk cycles per one-row drop step (DROP_ANIM_EN only)
// PORTS
// - clk        in   1     system clock
// - rst        in   1     asynchronous, active-low reset
// - left       in   1     raw button; move cursor one column left
// - right      in   1     raw button; move cursor one column right
// - put        in   1     raw button; drop a token in the cursor column
// - new_game   in   1     synchronous level; clear board and restart
// - win        in   1     winner exists on the current panel
// - full       in   1     panel full
// - cursor     out  COLS  one-hot selected column
// - turn       out  1     0 = player A, 1 = player B
// - wr_en      out  1     one-cycle panel write strobe
// - wr_col     out  3     write column, 0..COLS-1
// - wr_row     out  3     write row, 0..ROWS-1
// - wr_val     out  2     cell code: 01 = A, 10 = B
// - clr        out  1     one-cycle panel clear strobe
// - invalid    out  1     one-cycle illegal-move pulse
// - busy       out  1     move in progress; buttons ignored
// - anim_valid out  1     falling token visible
// - anim_row   out  3     row of the falling token
// BEHAVIOUR
// - Reset (rst=0):
//   - state IDLE; cursor = 7'b0001000 (column 3); turn = 0; heights all 0.
//   - All strobes 0; anim_row = 0.
// - Button inputs: 2-flop synchroniser, then rising-edge detect.
//   - A held button produces exactly one press.
// - Press priority in the same cycle: put > (left XOR right).
//   - left and right pressed together: no move.
// - Cursor wraps: left at column 0 goes to 6; right at column 6 goes to 0.
//   - Cursor changes on the cycle after the press; IDLE only.
// - States: IDLE, DROP, COMMIT, SETTLE, LOCKED, CLEAR.
// - IDLE, put press, column c:
//   - If heights[c] == ROWS: invalid = 1 for one cycle; stay in IDLE.
//   - Otherwise latch c and go to DROP (anim build) or COMMIT.
// - COMMIT:
//   - wr_en = 1 for exactly one cycle; wr_col = c; wr_row = heights[c]; wr_val = turn ? 2'b10 : 2'b01.
//   - heights[c] increments; next state SETTLE.
//   - Without animation, wr_en is asserted 1 cycle after the registered press.
// - SETTLE (one cycle, panel updated):
//   - win | full: go to LOCKED; turn is unchanged (turn = last mover).
//   - Otherwise turn toggles; go to IDLE.
// - busy = 1 in DROP, COMMIT, SETTLE, CLEAR. Presses arriving then are discarded; no invalid is raised.
// - LOCKED: left/right ignored; a put press raises invalid; exit only through new_game.
// - new_game = 1 in any state (highest priority) goes to CLEAR:
//   - An in-flight drop is aborted with no write.
//   - CLEAR: clr = 1 for one cycle; heights = 0; turn = 0; cursor = column 3; then IDLE.
// - Heights are 3-bit, saturating at ROWS; they never wrap.
// - Asynchronous reset mid-drop: immediate return to the reset values; no write.
// CONFIGURATION
// - SCORE4_DROP_ANIM_EN defined:
//   - DROP state: anim_valid = 1; anim_row starts at ROWS-1.
//   - anim_row decrements every TICK_DIV cycles until it equals heights[c], then COMMIT.
//   - Tick counter clears on DROP entry.
// - SCORE4_DROP_ANIM_EN undefined:
//   - No DROP state and no tick counter; anim_valid = 0 and anim_row = 0 constantly.
// STRUCTURE
// - score4_pkg:
//   - COLS, ROWS constants.
//   - cell_t enum {EMPTY = 2'b00, PA = 2'b01, PB = 2'b10}.
//   - ctrl_state_t enum; CURSOR_RST constant.
// - Sub-module score4_btn_edge: 3-bit synchroniser and rising-edge detector, instantiated once for left/right/put.
// TESTING
// - T1, reset: rst=0 then 1; 3 left presses -> cursor 7'b0000001; 1 more left -> 7'b1000000.
// - T2, commit: put on column 3 with turn=0 -> wr_en=1, wr_col=3, wr_row=0, wr_val=01; then turn=1.
//   - A second put -> wr_row=1, wr_val=10.
// - T3, full column: 6 puts on column 0, then a 7th -> invalid pulse for 1 cycle; no wr_en; turn unchanged.
// - T4, win lock: force win=1 in SETTLE -> LOCKED with turn held; put -> invalid=1; left -> cursor unchanged.
//   - new_game -> clr=1, turn=0, cursor=column 3.
// - T5, simultaneous: left+right same cycle -> no cursor change; put+left -> commit only, cursor unchanged.
// - T6, animation: with SCORE4_DROP_ANIM_EN, TICK_DIV=4, empty column -> anim_row 5,4,3,2,1,0 at 4-cycle steps, then wr_en.
//   - new_game mid-drop -> no wr_en; clr=1.

Source files
------------

// File: rtl/score4_pkg.sv
// Shared constants, cell codes and controller state encoding for the Score 4 move sequencer.
// Optional drop animation in score4_move_ctrl is enabled by defining SCORE4_DROP_ANIM_EN.
package score4_pkg;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        PA    = 2'b01,
        PB    = 2'b10
    } cell_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DROP   = 3'd1;
    localparam logic [2:0] S_COMMIT = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;
    localparam logic [2:0] S_CLEAR  = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        DROP   = S_DROP,
        COMMIT = S_COMMIT,
        SETTLE = S_SETTLE,
        LOCKED = S_LOCKED,
        CLEAR  = S_CLEAR
    } ctrl_state_t;

    localparam logic [COLS-1:0] CURSOR_RST = 7'b0001000;

    // Column heights saturate at the row count instead of wrapping.
    function automatic logic [2:0] next_height(input logic [2:0] h, input int rows);
        return (h >= 3'(rows)) ? h : h + 3'd1;
    endfunction

endpackage

// File: rtl/score4_btn_edge.sv
// Two-flop synchroniser plus registered rising-edge detector for the three raw buttons.
// A held button yields exactly one single-cycle press pulse.
module score4_btn_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    output logic [2:0] press
);

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            press <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            prev  <= sync2;
            press <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/score4_move_ctrl.sv
// Score 4 move sequencer: cursor, column heights, turn and game-over lock; drives panel writes.
// Define SCORE4_DROP_ANIM_EN to add the falling-token DROP state with its tick counter.
//
// state  | meaning
// IDLE   | waiting for a button press
// DROP   | token falling, one row per TICK_DIV cycles (animation build only)
// COMMIT | one-cycle panel write, height update
// SETTLE | panel updated; sample win/full
// LOCKED | game over; only new_game leaves
// CLEAR  | one-cycle panel clear
module score4_move_ctrl
    import score4_pkg::*;
#(
    parameter int COLS = score4_pkg::COLS,
    parameter int ROWS = score4_pkg::ROWS,
    parameter int unsigned TICK_DIV = 2_500_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            left,
    input  logic            right,
    input  logic            put,
    input  logic            new_game,
    input  logic            win,
    input  logic            full,
    output logic [COLS-1:0] cursor,
    output logic            turn,
    output logic            wr_en,
    output logic [2:0]      wr_col,
    output logic [2:0]      wr_row,
    output logic [1:0]      wr_val,
    output logic            clr,
    output logic            invalid,
    output logic            busy,
    output logic            anim_valid,
    output logic [2:0]      anim_row
);

    logic [2:0] press;
    logic       left_p;
    logic       right_p;
    logic       put_p;

    score4_btn_edge u_btn_edge (
        .clk     (clk),
        .rst     (rst),
        .btn_raw ({put, right, left}),
        .press   (press)
    );

    assign {put_p, right_p, left_p} = press;

    ctrl_state_t     state;
    logic [COLS-1:0] cursor_q;
    logic            turn_q;
    logic [2:0]      col_q;
    logic [2:0]      heights [COLS];
    logic            invalid_q;
    logic [2:0]      cur_col;
    logic [2:0]      cur_height;
    logic [2:0]      sel_height;

    function automatic logic [2:0] onehot_idx(input logic [COLS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < COLS; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign cur_col    = onehot_idx(cursor_q);
    assign cur_height = heights[cur_col];
    assign sel_height = heights[col_q];

`ifdef SCORE4_DROP_ANIM_EN
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);

    logic [2:0]        anim_row_q;
    logic [TICK_W-1:0] tick_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cursor_q  <= COLS'(CURSOR_RST);
            turn_q    <= 1'b0;
            col_q     <= '0;
            invalid_q <= 1'b0;
            for (int i = 0; i < COLS; i++) heights[i] <= '0;
`ifdef SCORE4_DROP_ANIM_EN
            anim_row_q <= '0;
            tick_cnt   <= '0;
`endif
        end else begin
            invalid_q <= 1'b0;
            // new_game overrides everything, including a drop in flight
            if (new_game) begin
                state    <= CLEAR;
                cursor_q <= COLS'(CURSOR_RST);
                turn_q   <= 1'b0;
                for (int i = 0; i < COLS; i++) heights[i] <= '0;
`ifdef SCORE4_DROP_ANIM_EN
                anim_row_q <= '0;
                tick_cnt   <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (put_p) begin
                            if (cur_height >= 3'(ROWS)) begin
                                invalid_q <= 1'b1;
                            end else begin
                                col_q <= cur_col;
`ifdef SCORE4_DROP_ANIM_EN
                                state      <= DROP;
                                anim_row_q <= 3'(ROWS - 1);
                                tick_cnt   <= TICK_RELOAD;
`else
                                state <= COMMIT;
`endif
                            end
                        end else if (left_p ^ right_p) begin
                            if (left_p) cursor_q <= {cursor_q[0], cursor_q[COLS-1:1]};
                            else        cursor_q <= {cursor_q[COLS-2:0], cursor_q[COLS-1]};
                        end
                    end
`ifdef SCORE4_DROP_ANIM_EN
                    DROP: begin
                        if (anim_row_q == sel_height) begin
                            state <= COMMIT;
                        end else if (tick_cnt == '0) begin
                            anim_row_q <= anim_row_q - 3'd1;
                            tick_cnt   <= TICK_RELOAD;
                        end else begin
                            tick_cnt <= tick_cnt - TICK_W'(1);
                        end
                    end
`endif
                    COMMIT: begin
                        heights[col_q] <= next_height(sel_height, ROWS);
                        state          <= SETTLE;
                    end
                    SETTLE: begin
                        if (win || full) begin
                            state <= LOCKED;
                        end else begin
                            turn_q <= ~turn_q;
                            state  <= IDLE;
                        end
                    end
                    LOCKED: begin
                        if (put_p) invalid_q <= 1'b1;
                    end
                    CLEAR: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cursor  = cursor_q;
    assign turn    = turn_q;
    assign wr_en   = (state == COMMIT) && !new_game;
    assign wr_col  = col_q;
    assign wr_row  = sel_height;
    assign wr_val  = turn_q ? 2'(PB) : 2'(PA);
    assign clr     = (state == CLEAR);
    assign invalid = invalid_q;
    assign busy    = (state == DROP) || (state == COMMIT) || (state == SETTLE) || (state == CLEAR);

`ifdef SCORE4_DROP_ANIM_EN
    assign anim_valid = (state == DROP);
    assign anim_row   = (state == DROP) ? anim_row_q : 3'd0;
`else
    assign anim_valid = 1'b0;
    assign anim_row   = 3'd0;
`endif

endmodule
